// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile
//   I2C target with an internal register file, clocked entirely by the system
//   clock. SCL/SDA are oversampled, synchronised and glitch-filtered. START,
//   repeated START and STOP are detected on the filtered lines. The first byte of
//   a write frame sets the register pointer. Later bytes are written at the
//   pointer, which then auto-increments. Reads return mem[pointer] and also
//   auto-increment. The block only ever pulls SDA low. It never drives SCL.
//
// Ports
//   clk_i         system clock (>= 20x SCL)
//   rst_i         asynchronous reset, active low
//   scl_i, sda_i  pad inputs
//   sda_oe_o      1 = pull SDA low
//   wr_valid_o    1-clk pulse per byte written into the register file
//   wr_addr_o     register index of that write
//   wr_data_o     data of that write
//   host_raddr_i  local read-port index
//   host_rdata_o  mem[host_raddr_i], combinational
//   busy_o        high from an accepted START until STOP
//
// State      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | bus free, waiting for START
// ADDR       | shifting in the device address and the R/W bit
// ADDR_ACK   | driving ACK for a matching address
// WR_BYTE    | shifting in a pointer byte or a data byte
// WR_ACK     | driving ACK for a received byte
// RD_BYTE    | driving mem[pointer] onto SDA, MSB first
// RD_ACK     | sampling the master's ACK/NACK
// WAIT_STOP  | SDA released, ignoring the bus until START or STOP

module i2c_target_regfile #(
    parameter int                    ADDR_WIDTH = 7,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] DEV_ADDR   = 7'h22,
    parameter int                    MEM_DEPTH  = 16,
    parameter int                    FILTER_LEN = 3,
    localparam int                   PW         = $clog2(MEM_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe_o,
    output logic                  wr_valid_o,
    output logic [PW-1:0]         wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    input  logic [PW-1:0]         host_raddr_i,
    output logic [DATA_WIDTH-1:0] host_rdata_o,
    output logic                  busy_o
);

    localparam int SW = (ADDR_WIDTH + 1 > DATA_WIDTH) ? ADDR_WIDTH + 1 : DATA_WIDTH;
    localparam int CW = $clog2(SW + 1);
    localparam logic [CW-1:0] ADDR_BITS = CW'(ADDR_WIDTH + 1);
    localparam logic [CW-1:0] DATA_BITS = CW'(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        WAIT_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input path. Index 0 = SCL, index 1 = SDA.
    // The newest window bit is the second synchroniser flop, so the
    // filtered level moves 2+FILTER_LEN clocks after the pad.
    // ------------------------------------------------------------------
    logic [1:0]            sync1_q;
    logic [FILTER_LEN-1:0] window_q [2];
    logic [1:0]            filt_q;
    logic [1:0]            filt_d_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync1_q  <= 2'b11;
            filt_q   <= 2'b11;
            filt_d_q <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                window_q[i] <= '1;
            end
        end else begin
            sync1_q  <= {sda_i, scl_i};
            filt_d_q <= filt_q;
            for (int i = 0; i < 2; i++) begin
                window_q[i] <= {window_q[i][FILTER_LEN-2:0], sync1_q[i]};
                if (&window_q[i]) begin
                    filt_q[i] <= 1'b1;
                end else if (~|window_q[i]) begin
                    filt_q[i] <= 1'b0;
                end
            end
        end
    end

    logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;

    assign scl_f     = filt_q[0];
    assign sda_f     = filt_q[1];
    assign scl_rise  = scl_f & ~filt_d_q[0];
    assign scl_fall  = ~scl_f & filt_d_q[0];
    // SCL must be high on both sides of the SDA edge for a bus condition.
    assign start_det = ~sda_f & filt_d_q[1] & scl_f & filt_d_q[0];
    assign stop_det  = sda_f & ~filt_d_q[1] & scl_f & filt_d_q[0];

    // ------------------------------------------------------------------
    // Protocol FSM and datapath
    // ------------------------------------------------------------------
    state_t                state_q, state_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [SW-1:0]         shift_q, shift_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic                  first_q, first_d;
    logic                  rw_q, rw_d;
    logic                  oe_q, oe_d;
    logic                  busy_q, busy_d;
    logic                  wv_q, wv_d;
    logic [PW-1:0]         wa_q, wa_d;
    logic [DATA_WIDTH-1:0] wd_q, wd_d;
    logic                  mem_we;
    logic [PW-1:0]         mem_wa;
    logic [DATA_WIDTH-1:0] mem_wd;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        first_d   = first_q;
        rw_d      = rw_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        wv_d      = 1'b0;
        wa_d      = wa_q;
        wd_d      = wd_q;
        mem_we    = 1'b0;
        mem_wa    = ptr_q;
        mem_wd    = shift_q[DATA_WIDTH-1:0];

        if (stop_det) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            oe_d      = 1'b0;
            bit_cnt_d = '0;
        end else if (start_det) begin
            state_d   = ADDR;
            busy_d    = 1'b1;
            oe_d      = 1'b0;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    oe_d = 1'b0;
                end
                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[SW-2:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else if (scl_fall && bit_cnt_q == ADDR_BITS) begin
                        bit_cnt_d = '0;
                        if (shift_q[ADDR_WIDTH:1] == DEV_ADDR) begin
                            state_d = ADDR_ACK;
                            oe_d    = 1'b1;
                            rw_d    = shift_q[0];
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (rw_q) begin
                            state_d = RD_BYTE;
                            tx_d    = mem_q[ptr_q];
                            oe_d    = ~mem_q[ptr_q][DATA_WIDTH-1];
                            ptr_d   = ptr_q + 1'b1;
                        end else begin
                            state_d = WR_BYTE;
                            oe_d    = 1'b0;
                            first_d = 1'b1;
                        end
                    end
                end
                WR_BYTE: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[SW-2:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else if (scl_fall && bit_cnt_q == DATA_BITS) begin
                        bit_cnt_d = '0;
                        state_d   = WR_ACK;
                        oe_d      = 1'b1;
                        if (first_q) begin
                            ptr_d   = shift_q[PW-1:0];
                            first_d = 1'b0;
                        end else begin
                            mem_we = 1'b1;
                            wv_d   = 1'b1;
                            wa_d   = ptr_q;
                            wd_d   = shift_q[DATA_WIDTH-1:0];
                            ptr_d  = ptr_q + 1'b1;
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        state_d = WR_BYTE;
                        oe_d    = 1'b0;
                    end
                end
                RD_BYTE: begin
                    // Entered on a falling edge, so every fall seen here
                    // closes a bit the master has already sampled.
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == DATA_BITS) begin
                            state_d   = RD_ACK;
                            oe_d      = 1'b0;
                            bit_cnt_d = '0;
                        end else begin
                            tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
                            oe_d = ~tx_q[DATA_WIDTH-2];
                        end
                    end
                end
                RD_ACK: begin
                    // bit_cnt doubles as an "ACK seen" flag here.
                    if (scl_rise) begin
                        if (sda_f) begin
                            state_d = WAIT_STOP;
                        end else begin
                            bit_cnt_d = CW'(1);
                        end
                    end else if (scl_fall && bit_cnt_q != '0) begin
                        state_d   = RD_BYTE;
                        bit_cnt_d = '0;
                        tx_d      = mem_q[ptr_q];
                        oe_d      = ~mem_q[ptr_q][DATA_WIDTH-1];
                        ptr_d     = ptr_q + 1'b1;
                    end
                end
                WAIT_STOP: begin
                    oe_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= '0;
            ptr_q     <= '0;
            first_q   <= 1'b0;
            rw_q      <= 1'b0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            wv_q      <= 1'b0;
            wa_q      <= '0;
            wd_q      <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            first_q   <= first_d;
            rw_q      <= rw_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            wv_q      <= wv_d;
            wa_q      <= wa_d;
            wd_q      <= wd_d;
            if (mem_we) begin
                mem_q[mem_wa] <= mem_wd;
            end
        end
    end

    assign sda_oe_o     = oe_q;
    assign busy_o       = busy_q;
    assign wr_valid_o   = wv_q;
    assign wr_addr_o    = wa_q;
    assign wr_data_o    = wd_q;
    assign host_rdata_o = mem_q[host_raddr_i];

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: a bit-banged I2C master drives the pad lines
// through a wired-AND with the target's SDA pull-down. Expected register
// writes go into a queue that a separate monitor drains on every wr_valid_o.

module tb_i2c_target_regfile;

    localparam int Q = 10;  // clk cycles per quarter SCL period

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       glitch = 1'b0;
    logic       sda_pad;
    logic       sda_oe;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] host_raddr = 4'd0;
    logic [7:0] host_rdata;
    logic       busy;

    int  n_tests = 0;
    int  n_fail = 0;
    wr_t exp_q[$];
    wr_t mon_e;
    logic oe_watch = 1'b0;
    int  oe_viol = 0;

    always #5 clk = ~clk;

    assign sda_pad = (sda_m & ~sda_oe) ^ glitch;

    i2c_target_regfile dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .scl_i        (scl_m),
        .sda_i        (sda_pad),
        .sda_oe_o     (sda_oe),
        .wr_valid_o   (wr_valid),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data),
        .host_raddr_i (host_raddr),
        .host_rdata_o (host_rdata),
        .busy_o       (busy)
    );

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // scoreboard monitor for the register-file write port
    always @(negedge clk) begin
        if (rst_n && wr_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wr_unexpected: got (%0h,%0h), expected no write", wr_addr, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", wr_addr, mon_e.a);
                check("wr_data", wr_data, mon_e.d);
            end
        end
    end

    always @(negedge clk) begin
        if (oe_watch && sda_oe) oe_viol++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic hq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; scl_m = 1'b1; hq();
        sda_m = 1'b0; hq();
        scl_m = 1'b0; hq();
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; hq();
        scl_m = 1'b1; hq();
        sda_m = 1'b0; hq();
        scl_m = 1'b0; hq();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; hq();
        scl_m = 1'b1; hq();
        sda_m = 1'b1; hq();
        hq();
    endtask

    // one SCL period; samples the pad mid-high, optional 1-clk glitch after
    task automatic clk_bit(input logic b, input logic g, output logic s);
        sda_m = b; hq();
        scl_m = 1'b1; hq();
        s = sda_pad;
        if (g) begin
            glitch = 1'b1;
            @(negedge clk);
            glitch = 1'b0;
        end
        hq();
        scl_m = 1'b0; hq();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_sda9,
                             input logic [7:0] gmask, input string nm);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], gmask[i], s);
        clk_bit(1'b1, 1'b0, s);
        check(nm, s, exp_sda9);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        logic s;
        for (int i = 7; i > 7 - n; i--) clk_bit(b[i], 1'b0, s);
    endtask

    task automatic recv_byte(input logic ack, input logic [7:0] exp, input string nm);
        logic       s;
        logic [7:0] r;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, 1'b0, s);
            r[i] = s;
        end
        clk_bit(ack, 1'b0, s);
        check(nm, r, exp);
    endtask

    task automatic host_chk(input logic [3:0] a, input logic [7:0] exp, input string nm);
        host_raddr = a;
        @(negedge clk);
        check(nm, host_rdata, exp);
    endtask

    logic s_tmp;

    initial begin
        repeat (5) @(negedge clk);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_valid", wr_valid, 0);
        host_chk(4'd3, 8'h00, "rst_mem3");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // write ptr 3, data A5 5A C3
        exp_q.push_back('{4'd3, 8'hA5});
        exp_q.push_back('{4'd4, 8'h5A});
        exp_q.push_back('{4'd5, 8'hC3});
        i2c_start();
        check("busy_in_frame", busy, 1);
        send_byte(8'h44, 1'b0, 8'h00, "ack_addr_w");
        send_byte(8'h03, 1'b0, 8'h00, "ack_ptr");
        send_byte(8'hA5, 1'b0, 8'h00, "ack_d0");
        send_byte(8'h5A, 1'b0, 8'h00, "ack_d1");
        send_byte(8'hC3, 1'b0, 8'h00, "ack_d2");
        i2c_stop();
        check("busy_after_stop", busy, 0);
        host_chk(4'd3, 8'hA5, "mem3");
        host_chk(4'd4, 8'h5A, "mem4");
        host_chk(4'd5, 8'hC3, "mem5");

        // pointer write, repeated START, read two bytes
        i2c_start();
        send_byte(8'h44, 1'b0, 8'h00, "ack_addr_w2");
        send_byte(8'h03, 1'b0, 8'h00, "ack_ptr2");
        i2c_rstart();
        send_byte(8'h45, 1'b0, 8'h00, "ack_addr_r");
        recv_byte(1'b0, 8'hA5, "rd_byte0");
        recv_byte(1'b1, 8'h5A, "rd_byte1");
        i2c_stop();
        // pointer must now be 5
        i2c_start();
        send_byte(8'h45, 1'b0, 8'h00, "ack_addr_r2");
        recv_byte(1'b1, 8'hC3, "rd_ptr5");
        i2c_stop();

        // wrong address: never drive SDA, no writes
        oe_viol = 0;
        oe_watch = 1'b1;
        i2c_start();
        send_byte(8'h46, 1'b1, 8'h00, "nack_addr");
        check("busy_mismatch", busy, 1);
        send_byte(8'h10, 1'b1, 8'h00, "nack_data");
        i2c_stop();
        oe_watch = 1'b0;
        check("oe_mismatch", oe_viol, 0);
        check("busy_mismatch_stop", busy, 0);

        // wrap-around
        exp_q.push_back('{4'd15, 8'h11});
        exp_q.push_back('{4'd0, 8'h22});
        i2c_start();
        send_byte(8'h44, 1'b0, 8'h00, "ack_addr_wrap");
        send_byte(8'h0F, 1'b0, 8'h00, "ack_ptr_wrap");
        send_byte(8'h11, 1'b0, 8'h00, "ack_wrap0");
        send_byte(8'h22, 1'b0, 8'h00, "ack_wrap1");
        i2c_stop();
        host_chk(4'd15, 8'h11, "mem15");
        host_chk(4'd0, 8'h22, "mem0");

        // partial byte abandoned by STOP
        exp_q.push_back('{4'd7, 8'h3C});
        i2c_start();
        send_byte(8'h44, 1'b0, 8'h00, "ack_addr_p");
        send_byte(8'h07, 1'b0, 8'h00, "ack_ptr_p");
        send_byte(8'h3C, 1'b0, 8'h00, "ack_d_p");
        i2c_stop();
        i2c_start();
        send_byte(8'h44, 1'b0, 8'h00, "ack_addr_p2");
        send_byte(8'h07, 1'b0, 8'h00, "ack_ptr_p2");
        send_bits(8'hA0, 4);
        i2c_stop();
        host_chk(4'd7, 8'h3C, "mem7_kept");
        host_chk(4'd8, 8'h00, "mem8_untouched");
        i2c_start();
        send_byte(8'h45, 1'b0, 8'h00, "ack_addr_r3");
        recv_byte(1'b1, 8'h3C, "rd_ptr7");
        i2c_stop();

        // 1-clk glitches on SDA while SCL high (false START and false STOP)
        exp_q.push_back('{4'd8, 8'h99});
        i2c_start();
        send_byte(8'h44, 1'b0, 8'h00, "ack_addr_g");
        send_byte(8'h08, 1'b0, 8'h00, "ack_ptr_g");
        send_byte(8'h99, 1'b0, 8'h84, "ack_d_g");
        i2c_stop();
        host_chk(4'd8, 8'h99, "mem8_glitch");

        // reset during a read byte (mem[4]=5A, MSB 0 -> SDA pulled low)
        i2c_start();
        send_byte(8'h44, 1'b0, 8'h00, "ack_addr_rst");
        send_byte(8'h04, 1'b0, 8'h00, "ack_ptr_rst");
        i2c_rstart();
        send_byte(8'h45, 1'b0, 8'h00, "ack_addr_rst_r");
        check("oe_before_rst", sda_oe, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_oe", sda_oe, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_wr_valid", wr_valid, 0);
        check("rst_mid_wr_addr", wr_addr, 0);
        check("rst_mid_wr_data", wr_data, 0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        host_chk(4'd3, 8'h00, "rst_mid_mem3");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // normal frame after reset
        exp_q.push_back('{4'd2, 8'h77});
        i2c_start();
        send_byte(8'h44, 1'b0, 8'h00, "ack_addr_post");
        send_byte(8'h02, 1'b0, 8'h00, "ack_ptr_post");
        send_byte(8'h77, 1'b0, 8'h00, "ack_d_post");
        i2c_stop();
        host_chk(4'd2, 8'h77, "mem2_post");
        i2c_start();
        send_byte(8'h45, 1'b0, 8'h00, "ack_addr_post_r");
        recv_byte(1'b1, 8'h00, "rd_ptr3_post");
        i2c_stop();

        repeat (10) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
